// File: rtl/iscas_bist_pkg.sv
// Shared types and constants for the ISCAS benchmark BIST controller.
// Holds the FSM state enum, LFSR/MISR taps and the seed fix-up helpers.
package iscas_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // x^16+x^14+x^13+x^11+1 : feedback from bits 15,13,12,10
  localparam logic [15:0] BIST_TAPS     = 16'hB400;
  localparam logic [15:0] SEED_ZERO_SUB = 16'h0001;
  localparam logic [15:0] LFSR_RST      = 16'h0001;
  localparam logic [15:0] MISR_RST      = 16'h0000;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] q,
    input logic [15:0] taps
  );
    return {q[14:0], ^(q & taps)};
  endfunction

  // An all-zero seed would lock the LFSR up
  function automatic logic [15:0] fix_seed(
    input logic [15:0] s
  );
    return (s == 16'h0000) ? SEED_ZERO_SUB : s;
  endfunction

endpackage

// File: rtl/iscas_bist_lfsr16.sv
// 16-bit load/shift register with xor data-in; LFSR when din=0, MISR otherwise.
// Ports: clk, rst_n, load/load_val (priority), shift, din, q (state).
module iscas_bist_lfsr16
  import iscas_bist_pkg::*;
#(
  parameter logic [15:0] TAPS    = BIST_TAPS,
  parameter logic [15:0] RST_VAL = LFSR_RST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        shift,
  input  logic [15:0] din,
  output logic [15:0] q
);

  logic [15:0] nxt;

  always_comb begin
    nxt = q;
    if (load) begin
      nxt = load_val;
    end else if (shift) begin
      nxt = lfsr_step(q, TAPS) ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/iscas_bist_ctrl.sv
// BIST controller for an ISCAS benchmark: flush, LFSR-driven run, MISR compaction.
// Ports: start_i/abort_i/num_cycles_i/seed_i/golden_i control, dut_in_o/dut_out_i
// to the benchmark, busy_o/done_o/pass_o/signature_o status (all registered).
module iscas_bist_ctrl
  import iscas_bist_pkg::*;
#(
  parameter int              IN_W         = 3,
  parameter int              OUT_W        = 6,
  parameter int              FLUSH_CYCLES = 4,
  parameter logic [IN_W-1:0] FLUSH_VEC    = IN_W'(1),
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_cycles_i,
  input  logic [15:0]      seed_i,
  input  logic [15:0]      golden_i,
  input  logic [OUT_W-1:0] dut_out_i,
  output logic [IN_W-1:0]  dut_in_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [15:0]      signature_o
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST =
    FW'(FLUSH_CYCLES - 1);

  state_t state;
  state_t state_d;

  logic [FW-1:0]    flush_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic             run_first;

  logic accept;
  logic leave;

  logic        lfsr_shift;
  logic        misr_shift;
  logic [15:0] lfsr_q;
  logic [15:0] misr_din;

  logic [IN_W-1:0] lfsr_lo;
  logic [IN_W-1:0] dut_in_d;
  logic            busy_d;
  logic            done_d;
  logic            pass_d;

  assign accept = (state == S_IDLE) && start_i
                  && !abort_i;
  assign leave  = (state != S_IDLE) && abort_i;

  // ---- state register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
      run_cnt   <= '0;
      run_first <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        flush_cnt <= FLUSH_LAST;
        run_cnt   <= num_cycles_i;
      end else begin
        if (state == S_FLUSH && flush_cnt != '0)
          flush_cnt <= flush_cnt - FW'(1);
        if (state == S_RUN && run_cnt != '0)
          run_cnt <= run_cnt - CNT_W'(1);
      end
      run_first <= (state_d == S_RUN)
                   && (state != S_RUN);
    end
  end

  // ---- next-state
  always_comb begin
    state_d = state;
    if (leave) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) state_d = S_FLUSH;
        end
        S_FLUSH: begin
          if (flush_cnt == '0)
            state_d = (run_cnt == '0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (run_cnt <= CNT_W'(1))
            state_d = S_DRAIN;
        end
        S_DRAIN: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---- pattern generator and response compactor
  // Benchmark outputs lag inputs by one cycle, so the MISR
  // skips the first RUN cycle and catches up in DRAIN.
  assign lfsr_shift = (state == S_RUN) && !abort_i;
  assign misr_shift = ((state == S_RUN && !run_first)
                      || state == S_DRAIN) && !abort_i;
  assign misr_din   = 16'(dut_out_i);

  iscas_bist_lfsr16 #(
    .TAPS    (BIST_TAPS),
    .RST_VAL (LFSR_RST)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (fix_seed(seed_i)),
    .shift    (lfsr_shift),
    .din      (16'h0000),
    .q        (lfsr_q)
  );

  iscas_bist_lfsr16 #(
    .TAPS    (BIST_TAPS),
    .RST_VAL (MISR_RST)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (MISR_RST),
    .shift    (misr_shift),
    .din      (misr_din),
    .q        (signature_o)
  );

  // ---- registered outputs, decoded from the next state
  // dut_in_o must show the LFSR value it will hold next cycle.
  always_comb begin
    lfsr_lo = lfsr_shift
              ? IN_W'(lfsr_step(lfsr_q, BIST_TAPS))
              : IN_W'(lfsr_q);
    dut_in_d = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      S_FLUSH: begin
        dut_in_d = FLUSH_VEC;
        busy_d   = 1'b1;
      end
      S_RUN: begin
        dut_in_d = lfsr_lo;
        busy_d   = 1'b1;
      end
      S_DRAIN: busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
    pass_d = pass_o;
    unique case (1'b1)
      accept || leave:
        pass_d = 1'b0;
      state == S_DONE:
        pass_d = (signature_o == golden_i);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in_o <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      pass_o   <= 1'b0;
    end else begin
      dut_in_o <= dut_in_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
      pass_o   <= pass_d;
    end
  end

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
// Testbench for iscas_bist_ctrl: randomized runs against a behavioural model
// of the flush/run/drain sequence, pattern stream and MISR signature.
module tb_iscas_bist_ctrl;

  localparam int F = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] num_cycles_i = '0;
  logic [15:0] seed_i = '0;
  logic [15:0] golden_i = '0;
  logic [5:0]  dut_out_i;
  logic [2:0]  dut_in_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [15:0] signature_o;

  logic        closed = 1'b0;
  logic [5:0]  hold = '0;
  logic [5:0]  bq = '0;
  logic [15:0] last_sig;

  int n_run  = 0;
  int n_fail = 0;

  iscas_bist_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .num_cycles_i (num_cycles_i),
    .seed_i       (seed_i),
    .golden_i     (golden_i),
    .dut_out_i    (dut_out_i),
    .dut_in_o     (dut_in_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .signature_o  (signature_o)
  );

  always #5 clk = ~clk;

  // Small registered benchmark netlist stand-in
  function automatic logic [5:0] bfun(input logic [2:0] x);
    return {x[0] ^ x[2], x[1] & x[2], x[0] | x[1],
            ~x[2], x[1] ^ x[0], x[2]};
  endfunction

  always @(posedge clk) bq <= bfun(dut_in_o);
  assign dut_out_i = closed ? bq : hold;

  function automatic logic [15:0] m_lfsr(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] m_misr(
    input logic [15:0] m, input logic [5:0] d);
    return m_lfsr(m) ^ {10'b0, d};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int cnt,
                         input logic [15:0] seed,
                         input bit good,
                         input int abort_at,
                         input bit noise);
    logic [15:0] l;
    logic [15:0] sig;
    logic [15:0] gold;
    logic [2:0]  xq[$];
    int          total;
    l   = (seed == 16'h0) ? 16'h0001 : seed;
    sig = 16'h0;
    for (int k = 0; k < cnt; k++) begin
      xq.push_back(l[2:0]);
      sig = m_misr(sig, closed ? bfun(l[2:0]) : hold);
      l   = m_lfsr(l);
    end
    gold = good ? sig
                : sig ^ (16'h1 << $urandom_range(0, 15));
    last_sig = sig;
    total = F + cnt + ((cnt > 0) ? 1 : 0) + 1;
    golden_i     = gold;
    num_cycles_i = 16'(cnt);
    seed_i       = seed;
    start_i      = 1'b1;
    cyc;
    start_i      = 1'b0;
    num_cycles_i = 16'($urandom);
    seed_i       = 16'($urandom);
    chk("pass_clr", 32'(pass_o), 0);
    for (int i = 1; i <= total; i++) begin
      logic [2:0] ein;
      logic       eb;
      logic       ed;
      ein = 3'b000;
      eb  = 1'b1;
      ed  = 1'b0;
      if (i <= F) ein = 3'b001;
      else if (i <= F + cnt) ein = xq[i-F-1];
      else if (i == total) begin
        eb = 1'b0;
        ed = 1'b1;
      end
      chk("dut_in", 32'(dut_in_o), 32'(ein));
      chk("busy", 32'(busy_o), 32'(eb));
      chk("done", 32'(done_o), 32'(ed));
      if (i <= F) chk("sig_flush", 32'(signature_o), 0);
      start_i = noise && ($urandom_range(0, 2) == 0);
      if (i == abort_at) abort_i = 1'b1;
      cyc;
      start_i = 1'b0;
      if (abort_i) begin
        abort_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_in", 32'(dut_in_o), 0);
        chk("abort_pass", 32'(pass_o), 0);
        for (int j = 0; j < 3; j++) begin
          chk("abort_done", 32'(done_o), 0);
          chk("abort_idle", 32'(busy_o), 0);
          cyc;
        end
        return;
      end
    end
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_done", 32'(done_o), 0);
    chk("sig", 32'(signature_o), 32'(sig));
    chk("pass", 32'(pass_o), 32'(gold == sig));
  endtask

  initial begin
    int c;
    logic [15:0] s;
    rst_n = 1'b0;
    repeat (2) cyc;
    chk("rst_in", 32'(dut_in_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_pass", 32'(pass_o), 0);
    chk("rst_sig", 32'(signature_o), 0);
    rst_n = 1'b1;

    // zero-length run: flush then straight to done
    closed = 1'b0;
    hold   = 6'h00;
    run_txn(0, 16'h1234, 1'b1, 0, 1'b0);
    run_txn(0, 16'h1234, 1'b0, 0, 1'b0);

    // single pattern, quiet outputs
    run_txn(1, 16'h0001, 1'b1, 0, 1'b0);
    chk("one_sig", 32'(signature_o), 0);

    // zero seed, constant response 1
    hold = 6'h01;
    run_txn(3, 16'h0000, 1'b1, 0, 1'b0);
    chk("three_sig", 32'(signature_o), 32'h0007);

    // abort in the second RUN cycle, then a clean run
    closed = 1'b1;
    s = 16'($urandom);
    run_txn(10, s, 1'b1, F + 2, 1'b0);
    run_txn(10, s, 1'b1, 0, 1'b0);

    // stray start pulses while busy and in DONE
    run_txn(8, 16'($urandom), 1'b1, 0, 1'b1);

    // asynchronous reset mid-run
    golden_i     = 16'h0;
    num_cycles_i = 16'd20;
    seed_i       = 16'h0005;
    start_i      = 1'b1;
    cyc;
    start_i = 1'b0;
    repeat (F + 3) cyc;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy_o), 0);
    chk("mrst_in", 32'(dut_in_o), 0);
    chk("mrst_sig", 32'(signature_o), 0);
    cyc;
    chk("mrst_done", 32'(done_o), 0);
    rst_n = 1'b1;
    run_txn(5, 16'h00a5, 1'b1, 0, 1'b0);

    // randomized runs
    for (int t = 0; t < 25; t++) begin
      int ab;
      closed = ($urandom_range(0, 1) == 1);
      hold   = 6'($urandom);
      c      = $urandom_range(0, 40);
      s      = ($urandom_range(0, 4) == 0) ? 16'h0
                                           : 16'($urandom);
      ab = 0;
      if ($urandom_range(0, 3) == 0)
        ab = $urandom_range(1, F + c + ((c > 0) ? 1 : 0));
      run_txn(c, s, ($urandom_range(0, 1) == 1), ab,
              ($urandom_range(0, 1) == 1));
    end

    // long closed-loop runs, good then corrupted golden
    closed = 1'b1;
    s = 16'($urandom);
    run_txn(1000, s, 1'b1, 0, 1'b0);
    chk("long_pass", 32'(pass_o), 1);
    run_txn(1000, s, 1'b0, 0, 1'b0);
    chk("long_bad", 32'(pass_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/iscas_bist_ctrl.md
ISCAS_BIST_CTRL -- requirements
Module: iscas_bist_ctrl

Interface
REQ-001 Parameter IN_W, default 3, width of the benchmark primary-input vector.
REQ-002 Parameter OUT_W, default 6, width of the benchmark primary-output vector (OUT_W <= MISR_W).
REQ-003 Parameter FLUSH_CYCLES, default 4, number of flush cycles (>= 1).
REQ-004 Parameter FLUSH_VEC, default IN_W'b001, input vector driven during flush (bit0 = G0 = benchmark clear).
REQ-005 Parameter CNT_W, default 16, width of the run-length counter.
REQ-006 Port clk input 1: single clock, rising edge; one clock drives the block and the benchmark under test.
REQ-007 Port rst_n input 1: reset, asynchronous, active-low.
REQ-008 Port start_i input 1: start pulse, sampled only in IDLE.
REQ-009 Port abort_i input 1: synchronous abort, sampled in any state.
REQ-010 Port num_cycles_i input CNT_W: RUN length, latched on accepted start.
REQ-011 Port seed_i input 16: LFSR seed, latched on accepted start.
REQ-012 Port golden_i input 16: expected signature, compared in DONE.
REQ-013 Port dut_out_i input OUT_W: benchmark primary outputs (registered inside benchmark).
REQ-014 Port dut_in_o output IN_W: benchmark primary inputs.
REQ-015 Port busy_o output 1: high in FLUSH, RUN, DRAIN.
REQ-016 Port done_o output 1: one-cycle pulse in DONE.
REQ-017 Port pass_o output 1: signature == golden_i, registered in DONE, held until next accepted start.
REQ-018 Port signature_o output 16: current MISR contents.

Function
REQ-019 FSM states IDLE, FLUSH, RUN, DRAIN, DONE; all outputs registered.
REQ-020 IDLE & start_i -> FLUSH; latch num_cycles_i and seed_i; seed 16'h0000 replaced by 16'h0001; clear MISR to 16'h0000; clear pass_o.
REQ-021 FLUSH: dut_in_o = FLUSH_VEC for exactly FLUSH_CYCLES cycles; MISR frozen; then RUN, or DONE directly if latched count == 0.
REQ-022 RUN: dut_in_o = lfsr[IN_W-1:0]; LFSR advances every RUN cycle; lasts exactly latched-count cycles; then DRAIN.
REQ-023 LFSR: 16-bit Fibonacci, shift left, feedback = xor of bits 15,13,12,10 (x^16+x^14+x^13+x^11+1).
REQ-024 MISR: next = {misr[14:0], xor of misr bits 15,13,12,10} ^ zero-extended dut_out_i.
REQ-025 MISR updates in every RUN cycle except the first and in the single DRAIN cycle (one-cycle benchmark output latency); total updates = count.
REQ-026 DRAIN: dut_in_o = 0; one cycle; then DONE.
REQ-027 DONE: done_o = 1 one cycle; pass_o <= (signature == golden_i); then IDLE.
REQ-028 IDLE/DONE: dut_in_o = 0; busy_o = 0.
REQ-029 start_i while not IDLE ignored; start_i in DONE ignored.
REQ-030 abort_i in any non-IDLE state -> IDLE next cycle, no done_o, pass_o = 0, MISR retained; abort_i has priority over start_i.
REQ-031 Count = 2^CNT_W-1 runs without wrap; counter is down-counter stopping at zero.

Reset
REQ-032 rst_n low: state IDLE; dut_in_o, busy_o, done_o, pass_o = 0; signature_o = 16'h0000; LFSR = 16'h0001; counters = 0.
REQ-033 Reset mid-run aborts immediately; no done_o on release; IDLE accepts start on the first cycle after release.

Structure
REQ-034 Shared package iscas_bist_pkg holds state enum, LFSR/MISR tap constant 16'hB400, and seed-zero replacement value.
REQ-035 One sub-module: iscas_bist_lfsr16 (parameterised load/shift register, reused for LFSR and MISR with data-in port).

Verification
REQ-036 Reset, start with count 0 -> 4 FLUSH cycles with dut_in_o = 3'b001, done_o on cycle 5, signature_o = 16'h0000, pass_o = (golden_i == 0).
REQ-037 count 1, seed 16'h0001, dut_out_i held 6'h00 -> dut_in_o = 3'b001 for one RUN cycle, one MISR update, signature_o = 16'h0000.
REQ-038 count 3, seed 16'h0000, dut_out_i held 6'h01 -> LFSR starts at 16'h0001, dut_in_o sequence 1,2,4, signature_o = 16'h0007, done_o 4+3+1 cycles after start.
REQ-039 abort_i in RUN cycle 2 with count 10 -> busy_o low next cycle, no done_o, pass_o = 0; next start runs normally.
REQ-040 start_i pulsed during RUN and during DONE -> ignored, exactly one done_o per accepted start.
REQ-041 Closed loop with benchmark netlist, count 1000, golden from reference model -> pass_o = 1; corrupt one golden bit -> pass_o = 0.
